// File: rtl/calc_sequencer.sv
// calc_sequencer: BCD calculator front-end sequencer.
// Collects two BCD operands digit by digit, selects an ALU operation,
// launches the ALU and holds the result for display.
// Optional feature: define CALC_SEQ_TIMEOUT_EN to add an EXEC watchdog
// that moves to ERROR after TIMEOUT_CYCLES cycles without a result.
module calc_sequencer #(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ent_pulse,
   input  logic                      clr_pulse,
   input  logic [NUM_DIGITS-1:0]     inc_pulse,
   input  logic                      arith_pulse,
   input  logic                      alu_done,
   input  logic [4*NUM_DIGITS-1:0]   alu_result,
   output logic [4*NUM_DIGITS-1:0]   operand_a,
   output logic [4*NUM_DIGITS-1:0]   operand_b,
   output logic [1:0]                alu_op,
   output logic                      alu_start,
   output logic [4*NUM_DIGITS-1:0]   disp_value,
   output logic [2:0]                state,
   output logic                      err
);

   localparam int W = 4 * NUM_DIGITS;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_SEL_OP  = 3'd2,
      S_EXEC    = 3'd3,
      S_RESULT  = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   // A zero timeout would make EXEC unreachable in a meaningful way.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("calc_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   // Each selected digit counts 0..9 and wraps with no carry into its neighbour.
   function automatic logic [W-1:0] bcd_digit_inc(input logic [W-1:0]          val,
                                                  input logic [NUM_DIGITS-1:0] sel);
      logic [W-1:0] res;
      res = val;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel[i]) begin
            if (val[4*i +: 4] >= 4'd9) res[4*i +: 4] = 4'd0;
            else                       res[4*i +: 4] = val[4*i +: 4] + 4'd1;
         end
      end
      return res;
   endfunction

   // Operation select rotates add -> sub -> mul -> add; 11 is never produced.
   function automatic logic [1:0] next_op(input logic [1:0] op);
      logic [1:0] res;
      case (op)
         OP_ADD:  res = OP_SUB;
         OP_SUB:  res = OP_MUL;
         default: res = OP_ADD;
      endcase
      return res;
   endfunction

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W-1:0]   r_operand_a;
   logic [W-1:0]   w_operand_a_nxt;
   logic [W-1:0]   r_operand_b;
   logic [W-1:0]   w_operand_b_nxt;
   logic [W-1:0]   r_result;
   logic [W-1:0]   w_result_nxt;
   logic [1:0]     r_alu_op;
   logic [1:0]     w_alu_op_nxt;
   logic           r_alu_start;
   logic           w_alu_start_nxt;
   logic           w_done_accept;

`ifdef CALC_SEQ_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic [CNT_W-1:0] w_tmo_cnt_nxt;
   logic             r_err;
   logic             w_err_nxt;
`endif

   // The launch cycle's alu_done belongs to a previous operation, so ignore it.
   assign w_done_accept = alu_done && !r_alu_start;

   // State register and all sequencer storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_ENTER_A;
         r_operand_a <= '0;
         r_operand_b <= '0;
         r_result    <= '0;
         r_alu_op    <= OP_ADD;
         r_alu_start <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
         r_tmo_cnt   <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_operand_a <= w_operand_a_nxt;
         r_operand_b <= w_operand_b_nxt;
         r_result    <= w_result_nxt;
         r_alu_op    <= w_alu_op_nxt;
         r_alu_start <= w_alu_start_nxt;
`ifdef CALC_SEQ_TIMEOUT_EN
         r_tmo_cnt   <= w_tmo_cnt_nxt;
         r_err       <= w_err_nxt;
`endif
      end
   end

   // Next-state and datapath update; clear overrides every other request.
   always_comb begin
      w_state_nxt     = r_state;
      w_operand_a_nxt = r_operand_a;
      w_operand_b_nxt = r_operand_b;
      w_result_nxt    = r_result;
      w_alu_op_nxt    = r_alu_op;
      w_alu_start_nxt = 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
      w_tmo_cnt_nxt   = r_tmo_cnt;
      w_err_nxt       = r_err;
`endif
      if (clr_pulse) begin
         w_state_nxt     = S_ENTER_A;
         w_operand_a_nxt = '0;
         w_operand_b_nxt = '0;
         w_result_nxt    = '0;
         w_alu_op_nxt    = OP_ADD;
`ifdef CALC_SEQ_TIMEOUT_EN
         w_tmo_cnt_nxt   = '0;
         w_err_nxt       = 1'b0;
`endif
      end else begin
         case (r_state)
            S_ENTER_A: begin
               w_operand_a_nxt = bcd_digit_inc(r_operand_a, inc_pulse);
               if (ent_pulse) w_state_nxt = S_ENTER_B;
            end
            S_ENTER_B: begin
               w_operand_b_nxt = bcd_digit_inc(r_operand_b, inc_pulse);
               if (ent_pulse) w_state_nxt = S_SEL_OP;
            end
            S_SEL_OP: begin
               if (arith_pulse) w_alu_op_nxt = next_op(r_alu_op);
               if (ent_pulse) begin
                  w_state_nxt     = S_EXEC;
                  w_alu_start_nxt = 1'b1;
`ifdef CALC_SEQ_TIMEOUT_EN
                  w_tmo_cnt_nxt   = '0;
`endif
               end
            end
            S_EXEC: begin
               if (w_done_accept) begin
                  w_result_nxt = alu_result;
                  w_state_nxt  = S_RESULT;
`ifdef CALC_SEQ_TIMEOUT_EN
                  w_tmo_cnt_nxt = '0;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  w_state_nxt   = S_ERROR;
                  w_err_nxt     = 1'b1;
                  w_tmo_cnt_nxt = '0;
               end else begin
                  w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
`endif
               end
            end
            S_RESULT: begin
               if (ent_pulse) begin
                  w_state_nxt     = S_ENTER_A;
                  w_operand_a_nxt = '0;
                  w_operand_b_nxt = '0;
               end
            end
            S_ERROR: begin
               w_state_nxt = S_ERROR;
            end
            default: begin
               w_state_nxt = S_ENTER_A;
            end
         endcase
      end
   end

   // Display source follows the state with no register in the path.
   always_comb begin
      disp_value = '0;
      case (r_state)
         S_ENTER_A: disp_value = r_operand_a;
         S_ENTER_B: disp_value = r_operand_b;
         S_SEL_OP:  disp_value = {{(W-2){1'b0}}, r_alu_op};
         S_EXEC:    disp_value = r_operand_b;
         S_RESULT:  disp_value = r_result;
         S_ERROR:   disp_value = {NUM_DIGITS{4'hE}};
         default:   disp_value = '0;
      endcase
   end

   assign operand_a = r_operand_a;
   assign operand_b = r_operand_b;
   assign alu_op    = r_alu_op;
   assign alu_start = r_alu_start;
   assign state     = r_state;

`ifdef CALC_SEQ_TIMEOUT_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: directed table, corner sequences and
// randomized traffic checked against a digit-level behavioural model.
module tb_calc_sequencer;

   localparam int ND  = 4;
   localparam int W   = 4 * ND;
   localparam int TMO = 16;
`ifdef CALC_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int ST_A   = 0;
   localparam int ST_B   = 1;
   localparam int ST_SEL = 2;
   localparam int ST_EX  = 3;
   localparam int ST_RES = 4;
   localparam int ST_ERR = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          ent, clr, arith, done;
   logic [ND-1:0] inc;
   logic [W-1:0]  res;
   logic [W-1:0]  operand_a, operand_b, disp_value;
   logic [1:0]    alu_op;
   logic          alu_start, err;
   logic [2:0]    state;

   always #5 clk = ~clk;

   calc_sequencer #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .ent_pulse(ent), .clr_pulse(clr),
      .inc_pulse(inc), .arith_pulse(arith), .alu_done(done), .alu_result(res),
      .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
      .alu_start(alu_start), .disp_value(disp_value), .state(state), .err(err)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: operands held as decimal digit arrays.
   int m_state;
   int m_a [ND];
   int m_b [ND];
   int m_res;
   int m_op;
   int m_age;   // EXEC cycles already completed
   bit m_err;

   function automatic int pack(input int d [ND]);
      int v = 0;
      for (int i = ND - 1; i >= 0; i--) v = v * 16 + d[i];
      return v;
   endfunction

   task automatic model_reset();
      m_state = ST_A;
      for (int i = 0; i < ND; i++) begin m_a[i] = 0; m_b[i] = 0; end
      m_res = 0; m_op = 0; m_age = 0; m_err = 1'b0;
   endtask

   task automatic model_step();
      if (clr) begin
         model_reset();
      end else begin
         case (m_state)
            ST_A: begin
               for (int i = 0; i < ND; i++) if (inc[i]) m_a[i] = (m_a[i] + 1) % 10;
               if (ent) m_state = ST_B;
            end
            ST_B: begin
               for (int i = 0; i < ND; i++) if (inc[i]) m_b[i] = (m_b[i] + 1) % 10;
               if (ent) m_state = ST_SEL;
            end
            ST_SEL: begin
               if (arith) m_op = (m_op + 1) % 3;
               if (ent) begin m_state = ST_EX; m_age = 0; end
            end
            ST_EX: begin
               if (done && m_age > 0) begin
                  m_res = int'(res); m_state = ST_RES;
               end else if (TMO_EN && (m_age + 1 >= TMO)) begin
                  m_state = ST_ERR; m_err = 1'b1;
               end else begin
                  m_age++;
               end
            end
            ST_RES: begin
               if (ent) begin
                  for (int i = 0; i < ND; i++) begin m_a[i] = 0; m_b[i] = 0; end
                  m_state = ST_A;
               end
            end
            default: ;
         endcase
      end
   endtask

   function automatic int exp_disp();
      int v = 0;
      case (m_state)
         ST_A:   v = pack(m_a);
         ST_B:   v = pack(m_b);
         ST_SEL: v = m_op;
         ST_EX:  v = pack(m_b);
         ST_RES: v = m_res;
         default: for (int i = 0; i < ND; i++) v = v * 16 + 14;
      endcase
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_all();
      check("state",     32'(state),      32'(m_state));
      check("disp",      32'(disp_value), 32'(exp_disp()));
      check("operand_a", 32'(operand_a),  32'(pack(m_a)));
      check("operand_b", 32'(operand_b),  32'(pack(m_b)));
      check("alu_op",    32'(alu_op),     32'(m_op));
      check("alu_start", 32'(alu_start),  32'(m_state == ST_EX && m_age == 0));
      check("err",       32'(err),        32'(m_err));
   endtask

   task automatic clear_inputs();
      ent = 0; clr = 0; inc = '0; arith = 0; done = 0; res = '0;
   endtask

   // One clock: DUT and model consume the present inputs, outputs compared after.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      clear_inputs();
   endtask

   task automatic go_exec();
      ent = 1; tick();
      ent = 1; tick();
      ent = 1; tick();
   endtask

   typedef struct {
      bit            ent, clr, arith, done;
      logic [ND-1:0] inc;
      logic [W-1:0]  res;
      int            exp_state;
      logic [W-1:0]  exp_disp;
      int            exp_op;
   } vec_t;

   vec_t tbl[$];

   function automatic void addv(bit e, bit c, logic [ND-1:0] i, bit a, bit d,
                                logic [W-1:0] r, int st, logic [W-1:0] dv, int op);
      vec_t v;
      v.ent = e; v.clr = c; v.inc = i; v.arith = a; v.done = d; v.res = r;
      v.exp_state = st; v.exp_disp = dv; v.exp_op = op;
      tbl.push_back(v);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      #12;
      check_all();
      check("reset_disp", 32'(disp_value), 32'h0);
      reset = 1'b0;

      // Digit entry with wrap, then a subtract launch, then clear racing enter.
      for (int k = 1; k <= 3; k++)  addv(0, 0, 4'b0001, 0, 0, 0, ST_A, W'(k), 0);
      for (int k = 1; k <= 12; k++) addv(0, 0, 4'b0010, 0, 0, 0, ST_A, W'(((k % 10) << 4) | 3), 0);
      addv(0, 0, 4'b0100, 0, 0, 0,        ST_A,   16'h0123, 0);
      addv(0, 1, 4'b0000, 0, 0, 0,        ST_A,   16'h0000, 0);
      addv(0, 0, 4'b0001, 0, 0, 0,        ST_A,   16'h0001, 0);
      addv(0, 0, 4'b0001, 0, 0, 0,        ST_A,   16'h0002, 0);
      addv(0, 0, 4'b0010, 0, 0, 0,        ST_A,   16'h0012, 0);
      addv(1, 0, 4'b0000, 0, 0, 0,        ST_B,   16'h0000, 0);
      for (int k = 1; k <= 4; k++)  addv(0, 0, 4'b0001, 0, 0, 0, ST_B, W'(k), 0);
      for (int k = 1; k <= 3; k++)  addv(0, 0, 4'b0010, 0, 0, 0, ST_B, W'((k << 4) | 4), 0);
      addv(1, 0, 4'b0000, 0, 0, 0,        ST_SEL, 16'h0000, 0);
      addv(0, 0, 4'b0000, 1, 0, 0,        ST_SEL, 16'h0001, 1);
      addv(1, 0, 4'b0000, 0, 0, 0,        ST_EX,  16'h0034, 1);
      addv(0, 0, 4'b0000, 0, 0, 0,        ST_EX,  16'h0034, 1);
      addv(0, 0, 4'b0000, 0, 1, 16'h9978, ST_RES, 16'h9978, 1);
      addv(0, 0, 4'b0001, 1, 0, 0,        ST_RES, 16'h9978, 1);
      addv(1, 0, 4'b0000, 0, 0, 0,        ST_A,   16'h0000, 1);
      addv(1, 0, 4'b0001, 0, 0, 0,        ST_B,   16'h0000, 1);
      for (int k = 1; k <= 5; k++)  addv(0, 0, 4'b0001, 0, 0, 0, ST_B, W'(k), 1);
      addv(1, 1, 4'b0000, 0, 0, 0,        ST_A,   16'h0000, 0);

      foreach (tbl[n]) begin
         ent = tbl[n].ent; clr = tbl[n].clr; inc = tbl[n].inc;
         arith = tbl[n].arith; done = tbl[n].done; res = tbl[n].res;
         tick();
         check("tbl_state", 32'(state),      32'(tbl[n].exp_state));
         check("tbl_disp",  32'(disp_value), 32'(tbl[n].exp_disp));
         check("tbl_op",    32'(alu_op),     32'(tbl[n].exp_op));
      end

      // alu_done alongside alu_start is ignored; a later one is taken.
      go_exec();
      check("launch_start", 32'(alu_start), 32'h1);
      done = 1; res = 16'h1234; tick();
      check("done_at_start_ignored", 32'(state), 32'(ST_EX));
      done = 1; res = 16'h0042; tick();
      check("done_later_taken", 32'(disp_value), 32'h0042);
      clr = 1; tick();

      // Clear aborts EXEC; a late alu_done must not revive it.
      go_exec();
      tick();
      clr = 1; tick();
      tick(); tick();
      done = 1; res = 16'h4321; tick();
      check("late_done_state", 32'(state), 32'(ST_A));
      check("late_done_disp",  32'(disp_value), 32'h0);

      // Async reset in EXEC, then a stray alu_done.
      go_exec();
      tick();
      #2 reset = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge clk);
      reset = 1'b0;
      done = 1; res = 16'h1111; tick();
      check("done_after_reset", 32'(state), 32'(ST_A));

      // EXEC with no answer.
      go_exec();
`ifdef CALC_SEQ_TIMEOUT_EN
      repeat (TMO - 1) tick();
      check("pre_timeout_state", 32'(state), 32'(ST_EX));
      tick();
      check("timeout_state", 32'(state), 32'(ST_ERR));
      check("timeout_err",   32'(err), 32'h1);
      check("timeout_disp",  32'(disp_value), 32'hEEEE);
      ent = 1; tick();
      check("error_sticky", 32'(state), 32'(ST_ERR));
      clr = 1; tick();
      check("error_clr_state", 32'(state), 32'(ST_A));
      check("error_clr_err",   32'(err), 32'h0);
      go_exec();
      repeat (TMO - 1) tick();
      done = 1; res = 16'h0777; tick();
      check("done_beats_timeout", 32'(state), 32'(ST_RES));
      clr = 1; tick();
`else
      repeat (100) tick();
      check("no_timeout_state", 32'(state), 32'(ST_EX));
      check("no_timeout_err",   32'(err), 32'h0);
      clr = 1; tick();
`endif

      // Async reset mid-cycle while showing a result.
      go_exec();
      tick();
      done = 1; res = 16'h5555; tick();
      check("result_reached", 32'(state), 32'(ST_RES));
      #3 reset = 1'b1;
      model_reset();
      #1;
      check_all();
      check("async_rst_disp", 32'(disp_value), 32'h0);
      #2 reset = 1'b0;

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         clr   = ($urandom % 50) == 0;
         ent   = ($urandom % 5) == 0;
         inc   = ND'($urandom & $urandom);
         arith = ($urandom % 4) == 0;
         done  = ($urandom % 6) == 0;
         res   = W'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter NUM_DIGITS, default 4: BCD digits per operand; operand width W = 4*NUM_DIGITS.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: EXEC cycles allowed before timeout (used only under CALC_SEQ_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ent_pulse  input  1  debounced enter, one-cycle pulse.
REQ-006 clr_pulse  input  1  debounced clear, one-cycle pulse.
REQ-007 inc_pulse  input  NUM_DIGITS  bit i = one-cycle increment request for digit i (digit 0 = least significant).
REQ-008 arith_pulse  input  1  one-cycle operation-select request.
REQ-009 alu_done  input  1  ALU result valid, one-cycle pulse.
REQ-010 alu_result  input  W  ALU result, valid while alu_done high.
REQ-011 operand_a, operand_b  output  W each  BCD operands to ALU.
REQ-012 alu_op  output  2  00 add, 01 sub, 10 mul; 11 never driven.
REQ-013 alu_start  output  1  one-cycle ALU launch pulse.
REQ-014 disp_value  output  W  value to display driver.
REQ-015 state  output  3  ENTER_A=0, ENTER_B=1, SEL_OP=2, EXEC=3, RESULT=4, ERROR=5.
REQ-016 err  output  1  timeout flag.

Function
REQ-017 ENTER_A: inc_pulse[i] increments digit i of operand_a mod 10 (9 wraps to 0, no carry) the next cycle; multiple set bits increment all selected digits the same cycle.
REQ-018 ENTER_A + ent_pulse -> ENTER_B; ENTER_B applies REQ-017 to operand_b; ENTER_B + ent_pulse -> SEL_OP.
REQ-019 inc_pulse and ent_pulse in the same cycle: increment applied to current operand and state advances.
REQ-020 SEL_OP: arith_pulse cycles alu_op add->sub->mul->add; inc_pulse ignored; ent_pulse -> EXEC.
REQ-021 alu_start high exactly in the first EXEC cycle, low otherwise.
REQ-022 EXEC: alu_done in any EXEC cycle with alu_start low latches alu_result into result register and moves to RESULT next cycle; alu_done coincident with alu_start or outside EXEC is ignored.
REQ-023 RESULT: inc_pulse and arith_pulse ignored; ent_pulse -> ENTER_A with operands cleared, alu_op retained.
REQ-024 arith_pulse outside SEL_OP is ignored.
REQ-025 clr_pulse in any state -> ENTER_A next cycle, operands, result and err cleared, alu_op = add; an EXEC in progress is aborted and later alu_done ignored.
REQ-026 clr_pulse wins over ent_pulse, inc_pulse and alu_done in the same cycle.
REQ-027 disp_value combinational from registers, zero latency: ENTER_A -> operand_a; ENTER_B -> operand_b; SEL_OP -> alu_op zero-extended to W; EXEC -> operand_b; RESULT -> result; ERROR -> all digits 0xE.

Reset
REQ-028 reset asserted asynchronously forces state ENTER_A, operand_a = operand_b = result = 0, alu_op = 00, alu_start = 0, err = 0, timeout counter = 0; disp_value = 0.
REQ-029 reset mid-EXEC aborts; alu_done after reset release is ignored.

Configuration
REQ-030 Macro CALC_SEQ_TIMEOUT_EN defined: counter counts EXEC cycles; reaching TIMEOUT_CYCLES without accepted alu_done -> ERROR, err = 1; ERROR exits only via clr_pulse or reset; alu_done on the timeout cycle wins over timeout.
REQ-031 Macro undefined: no counter, EXEC waits indefinitely, ERROR unreachable, err tied 0.

Verification
REQ-032 After reset, inc_pulse=0001 x3, 0010 x12, 0100 x1 -> operand_a = 0x0123 (digit 1 wrapped), state 0, disp_value 0x0123.
REQ-033 Enter A=0012, B=0034, arith_pulse x1, ent -> alu_op=01, alu_start one cycle, state 3; alu_done with alu_result=0x9978 two cycles later -> state 4, disp_value 0x9978.
REQ-034 clr_pulse and ent_pulse same cycle in ENTER_B with B=0005 -> state 0, operand_b 0, operand_a 0, alu_op 00.
REQ-035 clr_pulse in EXEC, then alu_done 3 cycles later -> state stays 0, result 0, disp_value 0.
REQ-036 With CALC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no alu_done -> state 5, err 1, disp_value 0xEEEE after 16 EXEC cycles; clr_pulse -> state 0, err 0. Without macro: state 3 after 100 cycles.
REQ-037 Async reset asserted mid-cycle in RESULT -> all outputs at REQ-028 values before next clk edge.
